regfile_scoreboard: RTL and testbench

- Parametrised register file: two combinational read ports, one write port, optional write-to-read bypass.
- Integrated per-register pending scoreboard so decode can detect RAW hazards against in-flight writes.
- Sits between decode (read, issue) and writeback (write) in the pipelined datapath.
- Successor to the fixed 32x64 register file. Adds reset, width/depth parameters, bypass and hazard tracking.

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 40 ++++
 rtl/regfile_scoreboard.sv | 70 +++++++
 tb/tb_regfile_scoreboard.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults, register-index type and zero-register helper for the
// register file and its pending scoreboard.
package rf_pkg;
  localparam int WIDTH_DEF    = 64;
  localparam int ADDR_W_DEF   = 5;
  localparam int ZERO_REG_DEF = 31;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

  function automatic logic is_zero_reg(input int idx, input int zero);
    return idx == zero;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits plus a running count of pending registers.
// State updates on the rising edge; set and clear are single-cycle strobes.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_vld,
  input  logic [ADDR_W-1:0]    set_idx,
  input  logic                 clr_vld,
  input  logic [ADDR_W-1:0]    clr_idx,
  output logic [2**ADDR_W-1:0] pending,
  output logic [ADDR_W:0]      pend_cnt
);
  localparam int CW = ADDR_W + 1;

  logic set_en, clr_en, inc, dec;

  assign set_en = set_vld && !is_zero_reg(int'(set_idx), ZERO_REG);
  assign clr_en = clr_vld && !is_zero_reg(int'(clr_idx), ZERO_REG);

  // A retiring write that collides with a fresh issue leaves the bit set,
  // so it must not decrement the count.
  assign inc = set_en && !pending[set_idx];
  assign dec = clr_en && pending[clr_idx] && !(set_en && (set_idx == clr_idx));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      if (clr_en) pending[clr_idx] <= 1'b0;
      if (set_en) pending[set_idx] <= 1'b1;
      pend_cnt <= pend_cnt + CW'(inc) - CW'(dec);
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with optional write-to-read bypass and a
// RAW-hazard scoreboard; reads are combinational, writes land on the edge.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [WIDTH-1:0]  BusA,
  output logic [WIDTH-1:0]  BusB,
  output logic              BusyA,
  output logic              BusyB,
  input  logic [ADDR_W-1:0] RW,
  input  logic [WIDTH-1:0]  BusW,
  input  logic              RegWr,
  input  logic              IssueVld,
  input  logic [ADDR_W-1:0] IssueRd,
  output logic [ADDR_W:0]   PendCnt
);
  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;
  logic             wr_en, zero_a, zero_b, fwd_a, fwd_b;

  assign wr_en  = RegWr && !is_zero_reg(int'(RW), ZERO_REG);
  assign zero_a = is_zero_reg(int'(RA), ZERO_REG);
  assign zero_b = is_zero_reg(int'(RB), ZERO_REG);
  assign fwd_a  = (BYPASS != 0) && RegWr && (RW == RA);
  assign fwd_b  = (BYPASS != 0) && RegWr && (RW == RB);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[RW] <= BusW;
    end
  end

  always_comb begin
    BusA = '0;
    BusB = '0;
    if (!zero_a) BusA = fwd_a ? BusW : regs[RA];
    if (!zero_b) BusB = fwd_b ? BusW : regs[RB];
  end

  // A register being written this cycle is already resolved by the bypass.
  assign BusyA = !zero_a && pending[RA] && !fwd_a;
  assign BusyB = !zero_b && pending[RB] && !fwd_b;

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (Clk),
    .rst      (Rst),
    .set_vld  (IssueVld),
    .set_idx  (IssueRd),
    .clr_vld  (RegWr),
    .clr_idx  (RW),
    .pending  (pending),
    .pend_cnt (PendCnt)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and random checks of regfile_scoreboard, with and without bypass.
module tb_regfile_scoreboard;
  import rf_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  reg_idx_t    RA, RB, RW, IssueRd;
  logic [63:0] BusW;
  logic        RegWr, IssueVld;
  logic [63:0] BusA, BusB, BusA0, BusB0;
  logic        BusyA, BusyB, BusyA0, BusyB0;
  logic [5:0]  PendCnt, PendCnt0;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_regs [32];
  bit          m_pend [32];

  always #5 Clk = ~Clk;

  regfile_scoreboard #(.WIDTH(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(1)) dut (
    .Clk(Clk), .Rst(Rst), .RA(RA), .RB(RB), .BusA(BusA), .BusB(BusB),
    .BusyA(BusyA), .BusyB(BusyB), .RW(RW), .BusW(BusW), .RegWr(RegWr),
    .IssueVld(IssueVld), .IssueRd(IssueRd), .PendCnt(PendCnt)
  );

  regfile_scoreboard #(.WIDTH(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Rst(Rst), .RA(RA), .RB(RB), .BusA(BusA0), .BusB(BusB0),
    .BusyA(BusyA0), .BusyB(BusyB0), .RW(RW), .BusW(BusW), .RegWr(RegWr),
    .IssueVld(IssueVld), .IssueRd(IssueRd), .PendCnt(PendCnt0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    foreach (m_pend[i]) if (m_pend[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    foreach (m_regs[i]) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic logic [63:0] exp_bus(input reg_idx_t a, input bit byp);
    if (a == 5'd31) return '0;
    if (byp && RegWr && RW == a) return BusW;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input reg_idx_t a, input bit byp);
    if (a == 5'd31) return 1'b0;
    if (byp && RegWr && RW == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".BusA"},    BusA,              exp_bus(RA, 1'b1));
    chk({tag, ".BusB"},    BusB,              exp_bus(RB, 1'b1));
    chk({tag, ".BusyA"},   64'(BusyA),        64'(exp_busy(RA, 1'b1)));
    chk({tag, ".BusyB"},   64'(BusyB),        64'(exp_busy(RB, 1'b1)));
    chk({tag, ".PendCnt"}, 64'(PendCnt),      64'(model_cnt()));
    chk({tag, ".nb.BusA"}, BusA0,             exp_bus(RA, 1'b0));
    chk({tag, ".nb.BusB"}, BusB0,             exp_bus(RB, 1'b0));
    chk({tag, ".nb.BusyA"}, 64'(BusyA0),      64'(exp_busy(RA, 1'b0)));
    chk({tag, ".nb.BusyB"}, 64'(BusyB0),      64'(exp_busy(RB, 1'b0)));
    chk({tag, ".nb.PendCnt"}, 64'(PendCnt0),  64'(model_cnt()));
  endtask

  // Architectural effect of one clock edge: write data, retire, then issue.
  task automatic commit();
    if (RegWr && RW != 5'd31) m_regs[RW] = BusW;
    if (RegWr) m_pend[RW] = 1'b0;
    if (IssueVld && IssueRd != 5'd31) m_pend[IssueRd] = 1'b1;
  endtask

  task automatic drive(input reg_idx_t ra, input reg_idx_t rb, input reg_idx_t rw,
                       input logic [63:0] w, input logic wr, input logic iv,
                       input reg_idx_t ird);
    RA = ra; RB = rb; RW = rw; BusW = w; RegWr = wr; IssueVld = iv; IssueRd = ird;
  endtask

  task automatic cycle(input string tag);
    @(negedge Clk);
    check_outputs(tag);
    @(posedge Clk);
    commit();
    #1;
  endtask

  initial begin
    Rst = 1'b1;
    drive(0, 0, 0, '0, 0, 0, 0);
    model_reset();
    #2;
    check_outputs("reset");
    @(posedge Clk);
    #1 Rst = 1'b0;

    // Reset in the middle of operation
    drive(0, 0, 3, 64'hAB, 1, 1, 8);
    cycle("rst_pre");
    drive(3, 8, 0, '0, 0, 0, 0);
    #2;
    chk("rst_pre.BusA", BusA, 64'hAB);
    chk("rst_pre.BusyB", 64'(BusyB), 64'd1);
    Rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mid.BusA", BusA, 64'h0);
    chk("rst_mid.BusyB", 64'(BusyB), 64'd0);
    chk("rst_mid.PendCnt", 64'(PendCnt), 64'd0);
    Rst = 1'b0;
    cycle("rst_post");

    // Zero register is neither written nor tracked
    drive(31, 31, 31, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 31);
    cycle("zero_wr");
    drive(31, 31, 0, '0, 0, 0, 0);
    #1;
    chk("zero.BusA", BusA, 64'h0);
    chk("zero.BusyA", 64'(BusyA), 64'd0);
    chk("zero.PendCnt", 64'(PendCnt), 64'd0);

    // Bypass vs. no bypass
    drive(0, 0, 5, 64'h1111, 1, 0, 0);
    cycle("byp_init");
    drive(5, 5, 5, 64'h1234, 1, 0, 0);
    #1;
    chk("byp.BusA", BusA, 64'h1234);
    chk("byp.BusB", BusB, 64'h1234);
    chk("nobyp.BusA_old", BusA0, 64'h1111);
    cycle("byp");
    drive(5, 5, 0, '0, 0, 0, 0);
    #1;
    chk("nobyp.BusA_new", BusA0, 64'h1234);

    // Scoreboard lifecycle
    drive(7, 0, 0, '0, 0, 1, 7);
    cycle("life_issue");
    drive(7, 0, 0, '0, 0, 0, 0);
    #1;
    chk("life.BusyA", 64'(BusyA), 64'd1);
    chk("life.PendCnt", 64'(PendCnt), 64'd1);
    drive(7, 7, 7, 64'h77, 1, 0, 0);
    #1;
    chk("life_wr.BusyA", 64'(BusyA), 64'd0);
    chk("life_wr.nb.BusyA", 64'(BusyA0), 64'd1);
    cycle("life_wr");
    drive(7, 0, 0, '0, 0, 0, 0);
    #1;
    chk("life_done.BusyA0", 64'(BusyA0), 64'd0);
    chk("life_done.PendCnt", 64'(PendCnt), 64'd0);

    // Set and clear of the same index in one cycle
    drive(9, 0, 0, '0, 0, 1, 9);
    cycle("sc_issue");
    drive(9, 9, 9, 64'h99, 1, 1, 9);
    cycle("sc_both");
    drive(9, 0, 0, '0, 0, 0, 0);
    #1;
    chk("sc.BusyA", 64'(BusyA), 64'd1);
    chk("sc.PendCnt", 64'(PendCnt), 64'd1);
    chk("sc.BusA", BusA, 64'h99);

    // Fill every trackable register
    for (int i = 0; i < 31; i++) begin
      drive(reg_idx_t'(i), 0, 0, '0, 0, 1, reg_idx_t'(i));
      cycle("fill");
    end
    drive(0, 0, 0, '0, 0, 0, 0);
    #1;
    chk("fill.PendCnt", 64'(PendCnt), 64'd31);
    drive(4, 4, 0, '0, 0, 1, 4);
    cycle("fill_reissue");
    chk("fill_reissue.PendCnt", 64'(PendCnt), 64'd31);
    drive(4, 4, 4, 64'h44, 1, 0, 0);
    cycle("fill_wr");
    chk("fill_wr.PendCnt", 64'(PendCnt), 64'd30);
    drive(4, 4, 4, 64'h45, 1, 0, 0);
    cycle("fill_wr2");
    chk("fill_wr2.PendCnt", 64'(PendCnt), 64'd30);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(reg_idx_t'($urandom_range(0, 31)), reg_idx_t'($urandom_range(0, 31)),
            reg_idx_t'($urandom_range(0, 31)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            reg_idx_t'($urandom_range(0, 31)));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
